// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter in front of a single-port
// synchronous 32-bit memory with one cycle of read latency. Grants are
// combinational, read data returns through a one-deep owner pipeline, and
// accesses beyond DEPTH are absorbed locally and raise a sticky error flag.
module mem_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 12288
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [3:0]        m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [31:0]       m0_writedata,
    output logic              m0_waitrequest,
    output logic [31:0]       m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [3:0]        m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [31:0]       m1_writedata,
    output logic              m1_waitrequest,
    output logic [31:0]       m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,

    input  logic              err_clr,
    output logic              err
);

    // One extra bit so a DEPTH equal to 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];

    logic              req0;
    logic              req1;
    logic              gnt0;
    logic              gnt1;
    logic              any_gnt;
    logic              last;

    logic [ADDR_W-1:0] g_addr;
    logic [3:0]        g_be;
    logic [31:0]       g_wdata;
    logic              g_write;
    logic              g_read;
    logic              g_in_range;

    logic              rd_valid;
    logic              rd_owner;
    logic              rd_oor;
    logic [31:0]       ret_data;

    // Pick at most one master; on contention the one not served last wins.
    always_comb begin
        req0 = m0_read | m0_write;
        req1 = m1_read | m1_write;
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (req0 && req1) begin
                gnt0 = last;
                gnt1 = ~last;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
        any_gnt = gnt0 | gnt1;
    end

    // Route the granted master's command; a simultaneous read+write is a write.
    always_comb begin
        g_addr  = '0;
        g_be    = '0;
        g_wdata = '0;
        g_write = 1'b0;
        g_read  = 1'b0;
        if (gnt1) begin
            g_addr  = m1_address;
            g_be    = m1_byteenable;
            g_wdata = m1_writedata;
            g_write = m1_write;
            g_read  = m1_read & ~m1_write;
        end else if (gnt0) begin
            g_addr  = m0_address;
            g_be    = m0_byteenable;
            g_wdata = m0_writedata;
            g_write = m0_write;
            g_read  = m0_read & ~m0_write;
        end
        g_in_range = ({1'b0, g_addr} < DEPTH_LIM);
    end

    assign m0_waitrequest = ~gnt0;
    assign m1_waitrequest = ~gnt1;

    assign mem_address    = g_addr;
    assign mem_byteenable = g_be;
    assign mem_writedata  = g_wdata;
    assign mem_chipselect = any_gnt & g_in_range;
    assign mem_write      = any_gnt & g_write & g_in_range;
    assign mem_clken      = ~reset;

    // Round-robin pointer; reset points at m1 so m0 wins the first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= 1'b1;
        end else if (gnt1) begin
            last <= 1'b1;
        end else if (gnt0) begin
            last <= 1'b0;
        end
    end

    // Remember who owns the read that completes next cycle and whether it was out of range.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_owner <= 1'b0;
            rd_oor   <= 1'b0;
        end else begin
            rd_valid <= any_gnt & g_read;
            rd_owner <= gnt1;
            rd_oor   <= ~g_in_range;
        end
    end

    // Sticky out-of-range flag; a new offending grant beats a clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (any_gnt && !g_in_range) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

    // Steer returning data to its owner, zero everywhere else.
    always_comb begin
        ret_data         = rd_oor ? 32'h0000_0000 : mem_readdata;
        m0_readdatavalid = rd_valid & ~rd_owner & ~reset;
        m1_readdatavalid = rd_valid &  rd_owner & ~reset;
        m0_readdata      = m0_readdatavalid ? ret_data : 32'h0000_0000;
        m1_readdata      = m1_readdatavalid ? ret_data : 32'h0000_0000;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a behavioural
// one-cycle-latency memory. Unwritten words read back as 0xC0DE0000 | addr.
module tb_mem_arbiter;

    localparam int ADDR_W = 14;
    localparam int DEPTH  = 12288;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic [3:0]        m0_byteenable, m1_byteenable;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [31:0]       m0_writedata, m1_writedata;
    logic              m0_waitrequest, m1_waitrequest;
    logic [31:0]       m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [31:0]       mem_writedata;
    logic [31:0]       mem_readdata;
    logic              err_clr, err;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] mem_model [int];

    mem_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
        .err_clr(err_clr), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_word(input int a);
        if (mem_model.exists(a)) return mem_model[a];
        return 32'hC0DE_0000 | a;
    endfunction

    // Behavioural memory: byte-masked writes, registered read data.
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                logic [31:0] w;
                w = model_word(int'(mem_address));
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) w[8*b +: 8] = mem_writedata[8*b +: 8];
                mem_model[int'(mem_address)] = w;
            end else begin
                mem_readdata <= model_word(int'(mem_address));
            end
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; err_clr = 1'b0;
        m0_address = '0; m1_address = '0; m0_byteenable = 4'hF; m1_byteenable = 4'hF;
        m0_read = 1'b1; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
        m0_writedata = '0; m1_writedata = '0;
        apply_stimulus(); apply_stimulus(); #1;
        check_output("rst_m0_wait", m0_waitrequest, 1);
        check_output("rst_m1_wait", m1_waitrequest, 1);
        check_output("rst_m0_rdv", m0_readdatavalid, 0);
        check_output("rst_m0_rdata", m0_readdata, 0);
        check_output("rst_cs", mem_chipselect, 0);
        check_output("rst_wr", mem_write, 0);
        check_output("rst_clken", mem_clken, 0);
        check_output("rst_err", err, 0);

        // Simultaneous reads right after reset release
        apply_stimulus();
        reset = 1'b0;
        m0_read = 1'b1; m0_address = 14'h0010;
        m1_read = 1'b1; m1_address = 14'h0020;
        #1;
        check_output("c0_m0_wait", m0_waitrequest, 0);
        check_output("c0_m1_wait", m1_waitrequest, 1);
        check_output("c0_addr", mem_address, 32'h0010);
        check_output("c0_cs", mem_chipselect, 1);
        check_output("c0_clken", mem_clken, 1);
        apply_stimulus();
        m0_read = 1'b0; #1;
        check_output("c1_m1_wait", m1_waitrequest, 0);
        check_output("c1_addr", mem_address, 32'h0020);
        check_output("c1_m0_rdv", m0_readdatavalid, 1);
        check_output("c1_m0_rdata", m0_readdata, 32'hC0DE0010);
        check_output("c1_m1_rdv", m1_readdatavalid, 0);
        check_output("c1_m1_rdata", m1_readdata, 0);
        apply_stimulus();
        m1_read = 1'b0; #1;
        check_output("c2_m1_rdv", m1_readdatavalid, 1);
        check_output("c2_m1_rdata", m1_readdata, 32'hC0DE0020);
        check_output("c2_m0_rdv", m0_readdatavalid, 0);

        // Partial write then read back
        apply_stimulus();
        m0_write = 1'b1; m0_address = 14'h0100; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'h3;
        #1;
        check_output("pw_wait", m0_waitrequest, 0);
        check_output("pw_wr", mem_write, 1);
        check_output("pw_be", mem_byteenable, 4'h3);
        check_output("pw_wdata", mem_writedata, 32'hDEADBEEF);
        apply_stimulus();
        m0_write = 1'b0; m0_read = 1'b1; m0_byteenable = 4'hF; #1;
        check_output("pr_wr", mem_write, 0);
        apply_stimulus();
        m0_read = 1'b0; #1;
        check_output("pr_rdv", m0_readdatavalid, 1);
        check_output("pr_rdata", m0_readdata, 32'hC0DEBEEF);

        // Zero byte-enable write is granted but leaves memory alone
        apply_stimulus();
        m0_write = 1'b1; m0_address = 14'h0300; m0_writedata = 32'hFFFFFFFF; m0_byteenable = 4'h0;
        #1;
        check_output("be0_wait", m0_waitrequest, 0);
        check_output("be0_be", mem_byteenable, 0);
        apply_stimulus();
        m0_write = 1'b0; m0_read = 1'b1; m0_byteenable = 4'hF;
        apply_stimulus();
        m0_read = 1'b0; #1;
        check_output("be0_rdata", m0_readdata, 32'hC0DE0300);

        // Read and write together behave as a write
        apply_stimulus();
        m0_read = 1'b1; m0_write = 1'b1; m0_address = 14'h0200; m0_writedata = 32'h12345678;
        #1;
        check_output("rw_wait", m0_waitrequest, 0);
        check_output("rw_wr", mem_write, 1);
        apply_stimulus();
        m0_write = 1'b0; m0_read = 1'b0; #1;
        check_output("rw_no_rdv", m0_readdatavalid, 0);
        apply_stimulus();
        m0_read = 1'b1; #1;
        apply_stimulus();
        m0_read = 1'b0; #1;
        check_output("rw_rdata", m0_readdata, 32'h12345678);

        // Out-of-range read, sticky error and clear precedence
        apply_stimulus();
        m1_read = 1'b1; m1_address = 14'h3000; #1;
        check_output("oor_wait", m1_waitrequest, 0);
        check_output("oor_cs", mem_chipselect, 0);
        check_output("oor_err_pre", err, 0);
        apply_stimulus();
        m1_read = 1'b0; #1;
        check_output("oor_rdv", m1_readdatavalid, 1);
        check_output("oor_rdata", m1_readdata, 0);
        check_output("oor_err", err, 1);
        apply_stimulus();
        err_clr = 1'b1; m1_write = 1'b1; m1_address = 14'h300C; m1_writedata = 32'hAAAA5555; #1;
        check_output("oorw_err_held", err, 1);
        check_output("oorw_wait", m1_waitrequest, 0);
        check_output("oorw_cs", mem_chipselect, 0);
        check_output("oorw_wr", mem_write, 0);
        apply_stimulus();
        m1_write = 1'b0; #1;
        check_output("set_wins", err, 1);
        apply_stimulus();
        err_clr = 1'b0; #1;
        check_output("err_cleared", err, 0);

        // Continuous contention: strict alternation, no bubbles
        apply_stimulus();
        m0_read = 1'b1; m0_address = 14'h0040;
        m1_read = 1'b1; m1_address = 14'h0050;
        #1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                apply_stimulus(); #1;
            end
            check_output("alt_m0_wait", m0_waitrequest, (k % 2 == 1));
            check_output("alt_m1_wait", m1_waitrequest, (k % 2 == 0));
            if (k > 0) begin
                check_output("alt_m0_rdv", m0_readdatavalid, (k % 2 == 1));
                check_output("alt_m1_rdv", m1_readdatavalid, (k % 2 == 0));
                check_output("alt_m0_rdata", m0_readdata, (k % 2 == 1) ? 32'hC0DE0040 : 32'h0);
                check_output("alt_m1_rdata", m1_readdata, (k % 2 == 0) ? 32'hC0DE0050 : 32'h0);
            end
        end
        apply_stimulus();
        m0_read = 1'b0; m1_read = 1'b0; #1;
        check_output("alt_last_m1_rdv", m1_readdatavalid, 1);
        check_output("alt_last_m1_rdata", m1_readdata, 32'hC0DE0050);
        check_output("alt_last_m0_rdv", m0_readdatavalid, 0);

        // Reset lands one cycle after a read grant
        apply_stimulus();
        m1_read = 1'b1; m1_address = 14'h3FFF;
        apply_stimulus();
        m1_read = 1'b0; m0_read = 1'b1; m0_address = 14'h0060; #1;
        check_output("mr_grant", m0_waitrequest, 0);
        apply_stimulus();
        reset = 1'b1; m1_read = 1'b1; #1;
        check_output("mr_rdv", m0_readdatavalid, 0);
        check_output("mr_rdata", m0_readdata, 0);
        check_output("mr_m0_wait", m0_waitrequest, 1);
        check_output("mr_m1_wait", m1_waitrequest, 1);
        check_output("mr_err", err, 0);
        check_output("mr_cs", mem_chipselect, 0);
        apply_stimulus(); #1;
        check_output("mr_rdv_held", m0_readdatavalid, 0);
        apply_stimulus();
        reset = 1'b0; m0_address = 14'h0070; m1_address = 14'h0080; #1;
        check_output("post_m0_wait", m0_waitrequest, 0);
        check_output("post_m1_wait", m1_waitrequest, 1);
        apply_stimulus();
        m0_read = 1'b0; #1;
        check_output("post_m1_grant", m1_waitrequest, 0);
        check_output("post_m0_rdata", m0_readdata, 32'hC0DE0070);
        apply_stimulus();
        m1_read = 1'b0; #1;
        check_output("post_m1_rdata", m1_readdata, 32'hC0DE0080);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
